// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// major opcodes and the select codes seen by the ALU, immediate extender
// and result/operand muxes in the datapath.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  // Major opcodes (instr[6:0]) understood by the control unit
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Immediate formats for the extender
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Register-file write-back source
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  // ALU operand B source
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Opcodes that flow through the EXEC state
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_IALU) ||
           (op == OP_R) || (op == OP_LUI);
  endfunction

  // Immediate format implied by an opcode; R-type has none, I is harmless
  function automatic logic [2:0] imm_type_of(input logic [6:0] op);
    logic [2:0] t;
    case (op)
      OP_STORE:  t = IMM_S;
      OP_BRANCH: t = IMM_B;
      OP_JAL:    t = IMM_J;
      OP_LUI:    t = IMM_U;
      default:   t = IMM_I;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
// SRA folds onto SRL and SLTU onto SLT since the ALU lacks them.
module alu_decoder
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_ctrl
);

  // Address generation and LUI use ADD, branches compare by SUB, else funct3
  always_comb begin
    alu_ctrl = ALU_ADD;
    if (opcode == OP_BRANCH) begin
      alu_ctrl = ALU_SUB;
    end else if ((opcode == OP_R) || (opcode == OP_IALU)) begin
      case (funct3)
        3'b000:  alu_ctrl = ((opcode == OP_R) && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b011:  alu_ctrl = ALU_SLT;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        3'b111:  alu_ctrl = ALU_AND;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/
// writeback over a shared req/ready memory port, drives datapath selects,
// flags illegal instructions (sticky) and counts retired instructions.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   instr,
  input  logic                    eq,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    adr_src,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    reg_write,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_ctrl,
  output logic [2:0]              imm_src,
  output logic [1:0]              result_src,
  output logic                    illegal,
  output logic [CNT_WIDTH-1:0]    retired
);

  state_t               state_reg;
  logic                 illegal_reg;
  logic [CNT_WIDTH-1:0] retired_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_load;
  logic       is_store;
  logic       is_r;
  logic       is_lui;
  logic       branch_ok;
  logic       branch_taken;
  logic [2:0] alu_op;
  logic [2:0] alu_sel;
  logic [2:0] imm_type;

  // Instruction fields not needed for control
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_r     = (opcode == OP_R);
  assign is_lui   = (opcode == OP_LUI);
  assign imm_type = imm_type_of(opcode);

  // Only BEQ and BNE are implemented; other branch conditions trap
  assign branch_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign branch_taken = (funct3 == 3'b000) ? eq : !eq;

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (alu_op)
  );

  // State sequencing plus the sticky illegal flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_exec_op(opcode)) begin
            state_reg <= S_EXEC;
          end else if (opcode == OP_BRANCH) begin
            state_reg <= S_BRANCH;
          end else if (opcode == OP_JAL) begin
            state_reg <= S_JUMP;
          end else begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_store) begin
              state_reg   <= S_FETCH;
              retired_reg <= retired_reg + CNT_WIDTH'(1);
            end else begin
              state_reg <= S_WB;
            end
          end
        end
        S_WB: begin
          state_reg   <= S_FETCH;
          retired_reg <= retired_reg + CNT_WIDTH'(1);
        end
        S_BRANCH: begin
          if (branch_ok) begin
            state_reg   <= S_FETCH;
            retired_reg <= retired_reg + CNT_WIDTH'(1);
          end else begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end
        end
        S_JUMP: begin
          state_reg   <= S_FETCH;
          retired_reg <= retired_reg + CNT_WIDTH'(1);
        end
        S_TRAP: begin
          state_reg <= S_TRAP;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  // Datapath controls from the current state and decoded instruction;
  // only the fetch-phase register enables look at mem_ready directly
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_sel    = ALU_ADD;
    imm_src    = IMM_I;
    result_src = RES_ALU;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
      end
      S_EXEC: begin
        alu_src_b = is_r ? SRCB_RS2 : SRCB_IMM;
        alu_sel   = alu_op;
        imm_src   = imm_type;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_we    = is_store;
        alu_src_b = SRCB_IMM;
        alu_sel   = alu_op;
        imm_src   = imm_type;
      end
      S_WB: begin
        reg_write = 1'b1;
        imm_src   = imm_type;
        if (is_load) begin
          result_src = RES_MEM;
        end else if (is_lui) begin
          result_src = RES_IMM;
        end else begin
          result_src = RES_ALU;
        end
      end
      S_BRANCH: begin
        alu_sel   = ALU_SUB;
        alu_src_b = SRCB_RS2;
        imm_src   = IMM_B;
        pc_src    = 1'b1;
        pc_write  = branch_ok && branch_taken;
      end
      S_JUMP: begin
        imm_src    = IMM_J;
        pc_src     = 1'b1;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
      end
      S_TRAP: begin
      end
      default: begin
      end
    endcase
  end

  assign alu_ctrl = ALU_OP_WIDTH'(alu_sel);
  assign illegal  = illegal_reg;
  assign retired  = retired_reg;

endmodule
